// File: rtl/totient_scan_driver.sv
// 3-digit multiplexed display driver for n and phi(n): tens of n, units of n, phi pattern.
// Double-buffered so a load never tears the frame currently on the display.
module totient_scan_driver #(
  parameter int DIV_WIDTH      = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       a_rst,
  input  logic       load,
  input  logic [3:0] n_in,
  input  logic [6:0] phi_seg,
  output logic [6:0] seg_out,
  output logic [2:0] dig_en,
  output logic       frame_done,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE, TENS, UNITS, PHI} state_t;

  localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] presc, presc_nxt;
  logic [3:0]           shadow_n, active_n;
  logic [6:0]           shadow_phi, active_phi;
  logic                 slot_end;
  logic                 wrap;
  logic [6:0]           seg_p0;
  logic [2:0]           dig_p0;

  function automatic logic [6:0] units_seg(input logic [3:0] n);
    logic [3:0] d;
    d = (n >= 4'd10) ? n - 4'd10 : n;
    case (d)
      4'd0:    units_seg = 7'h7E;
      4'd1:    units_seg = 7'h30;
      4'd2:    units_seg = 7'h6D;
      4'd3:    units_seg = 7'h79;
      4'd4:    units_seg = 7'h33;
      4'd5:    units_seg = 7'h5B;
      4'd6:    units_seg = 7'h5F;
      4'd7:    units_seg = 7'h70;
      4'd8:    units_seg = 7'h7F;
      default: units_seg = 7'h7B;
    endcase
  endfunction

  // Leading zero is suppressed: only a '1' ever appears in the tens digit.
  function automatic logic [6:0] tens_seg(input logic [3:0] n);
    tens_seg = (n >= 4'd10) ? 7'h30 : 7'h00;
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] seg);
    polarity = SEG_ACTIVE_LOW ? ~seg : seg;
  endfunction

  assign slot_end = (presc == {DIV_WIDTH{1'b1}});

  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    wrap      = 1'b0;
    seg_p0    = 7'h00;
    dig_p0    = 3'b000;
    case (state)
      IDLE: begin
        if (load) state_nxt = TENS;
      end
      TENS: begin
        seg_p0    = tens_seg(active_n);
        dig_p0    = 3'b100;
        presc_nxt = slot_end ? '0 : presc + 1'b1;
        if (slot_end) state_nxt = UNITS;
      end
      UNITS: begin
        seg_p0    = units_seg(active_n);
        dig_p0    = 3'b010;
        presc_nxt = slot_end ? '0 : presc + 1'b1;
        if (slot_end) state_nxt = PHI;
      end
      PHI: begin
        seg_p0    = active_phi;
        dig_p0    = 3'b001;
        presc_nxt = slot_end ? '0 : presc + 1'b1;
        if (slot_end) begin
          state_nxt = TENS;
          wrap      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state      <= IDLE;
      presc      <= '0;
      shadow_n   <= '0;
      shadow_phi <= '0;
      active_n   <= '0;
      active_phi <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      dig_en     <= 3'b000;
      seg_out    <= BLANK;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      frame_done <= wrap;
      dig_en     <= dig_p0;
      seg_out    <= polarity(seg_p0);
      if (load) begin
        shadow_n   <= n_in;
        shadow_phi <= phi_seg;
      end
      // A load on the frame-boundary edge bypasses shadow so it shows this frame.
      if ((state == IDLE && load) || (wrap && load)) begin
        active_n   <= n_in;
        active_phi <= phi_seg;
      end else if (wrap) begin
        active_n   <= shadow_n;
        active_phi <= shadow_phi;
      end
      if (state == IDLE && load) valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_totient_scan_driver.sv
// Directed bench for totient_scan_driver: one active-high and one active-low instance share stimulus.
module tb_totient_scan_driver;

  logic       clk = 1'b0;
  logic       a_rst;
  logic       load;
  logic [3:0] n_in;
  logic [6:0] phi_seg;
  logic [6:0] seg0, seg1;
  logic [2:0] dig0, dig1;
  logic       fd0, fd1;
  logic       vld0, vld1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  totient_scan_driver #(.DIV_WIDTH(2), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .a_rst(a_rst), .load(load), .n_in(n_in), .phi_seg(phi_seg),
    .seg_out(seg0), .dig_en(dig0), .frame_done(fd0), .valid(vld0)
  );

  totient_scan_driver #(.DIV_WIDTH(2), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .a_rst(a_rst), .load(load), .n_in(n_in), .phi_seg(phi_seg),
    .seg_out(seg1), .dig_en(dig1), .frame_done(fd1), .valid(vld1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_dig"},   {5'd0, dig0}, 8'h00);
    chk({tag, "_seg"},   {1'b0, seg0}, 8'h00);
    chk({tag, "_seglo"}, {1'b0, seg1}, 8'h7F);
    chk({tag, "_fd"},    {7'd0, fd0},  8'h00);
    chk({tag, "_fdlo"},  {7'd0, fd1},  8'h00);
  endtask

  // Checks 12 samples of one frame (4 per slot, DIV_WIDTH=2); optionally pulses load at sample load_at.
  task automatic run_frame(input string tag, input logic [6:0] et, input logic [6:0] eu,
                           input logic [6:0] ep, input int load_at,
                           input logic [3:0] ln, input logic [6:0] lp);
    logic [2:0] ed;
    logic [6:0] es;
    for (int i = 0; i < 12; i++) begin
      ed = (i < 4) ? 3'b100 : (i < 8) ? 3'b010 : 3'b001;
      es = (i < 4) ? et : (i < 8) ? eu : ep;
      chk({tag, "_dig"},   {5'd0, dig0}, {5'd0, ed});
      chk({tag, "_seg"},   {1'b0, seg0}, {1'b0, es});
      chk({tag, "_seglo"}, {1'b0, seg1}, {1'b0, ~es});
      chk({tag, "_fd"},    {7'd0, fd0},  (i == 11) ? 8'h01 : 8'h00);
      if (i == load_at) begin
        load    = 1'b1;
        n_in    = ln;
        phi_seg = lp;
      end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    a_rst   = 1'b1;
    load    = 1'b0;
    n_in    = 4'd0;
    phi_seg = 7'h00;
    #3;
    chk_blank("rst");
    chk("rst_valid", {7'd0, vld0}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;

    // Idle with no load: display stays blank, no frame pulses
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_blank("idle");
    end
    chk("idle_valid", {7'd0, vld0}, 8'h00);

    // First load: n=12, phi(12)=4
    load    = 1'b1;
    n_in    = 4'd12;
    phi_seg = 7'h33;
    tick();
    load = 1'b0;
    chk("load_valid", {7'd0, vld0}, 8'h01);
    chk("load_dig_lag", {5'd0, dig0}, 8'h00);
    tick();
    run_frame("f12a", 7'h30, 7'h6D, 7'h33, -1, 4'd0, 7'h00);
    // Mid-UNITS load of n=5 must not disturb the frame in progress
    run_frame("f12b", 7'h30, 7'h6D, 7'h33, 5, 4'd5, 7'h33);
    // Load coincident with the PHI->TENS edge is shown in the very next frame
    run_frame("f5", 7'h00, 7'h5B, 7'h33, 10, 4'd7, 7'h5F);
    run_frame("f7", 7'h00, 7'h70, 7'h5F, 10, 4'd10, 7'h33);
    run_frame("f10", 7'h30, 7'h7E, 7'h33, -1, 4'd0, 7'h00);

    // Reset in the middle of the PHI slot
    for (int i = 0; i < 9; i++) tick();
    chk("prerst_dig", {5'd0, dig0}, 8'h01);
    a_rst = 1'b1;
    #1;
    chk_blank("midrst");
    chk("midrst_valid", {7'd0, vld0}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_blank("postrst");
    end
    chk("postrst_valid", {7'd0, vld0}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
